// File: rtl/nr_arb_mux_pkg.sv
// Shared definitions for the arbitrated N-to-1 output multiplexer.
// Holds arbitration mode codes, the output-slot state encoding and the select-width helper.
package nr_pkg;

    localparam int NR_ARB_FIXED = 0;
    localparam int NR_ARB_RR    = 1;

    // The output slot state is the out_valid bit itself.
    typedef enum logic {
        NR_EMPTY = 1'b0,
        NR_FULL  = 1'b1
    } nr_state_e;

    function automatic int nr_sel_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/nr_arb_mux_if.sv
// Producer/consumer bundle for nr_arb_mux: N request channels in, one registered word out.
interface nr_arb_mux_if
    import nr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) ();

    localparam int SEL_W = nr_sel_width(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_sel;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );

endinterface

// File: rtl/nr_arb_mux_arbiter.sv
// Fixed-priority / round-robin arbiter with a one-hot grant and the rotating start pointer.
module nr_rr_arbiter
    import nr_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int MODE     = NR_ARB_FIXED,
    parameter int SEL_W    = nr_sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req,
    input  logic                en,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                grant_any
);

    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] idx_s;
    logic             found_s;
    int               pos_s;

    // Search requesters starting at ptr (round-robin) or at 0 (fixed), wrapping at CHANNELS-1.
    always_comb begin
        found_s = 1'b0;
        idx_s   = '0;
        pos_s   = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (MODE == NR_ARB_RR) begin
                pos_s = int'(ptr_r) + i;
            end else begin
                pos_s = i;
            end
            if (pos_s >= CHANNELS) begin
                pos_s = pos_s - CHANNELS;
            end else begin
                pos_s = pos_s;
            end
            if (!found_s && req[pos_s]) begin
                found_s = 1'b1;
                idx_s   = SEL_W'(pos_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Expand the winning index into the one-hot-or-zero grant vector.
    always_comb begin
        grant_any = en & found_s;
        grant_idx = idx_s;
        for (int c = 0; c < CHANNELS; c++) begin
            grant[c] = grant_any & (idx_s == SEL_W'(c));
        end
    end

    // Rotate the start pointer past the channel that just transferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if ((MODE == NR_ARB_RR) && grant_any) begin
            if (idx_s == SEL_W'(CHANNELS - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= idx_s + SEL_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/nr_arb_mux.sv
// Registered N-to-1 multiplexer: arbitrates among valid channels and loads one word per
// cycle into a single output slot, tagging each word with its source channel.
module nr_arb_mux
    import nr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = NR_ARB_FIXED
) (
    input  logic         clk,
    input  logic         rst,
    nr_arb_mux_if.slave  bus
);

    localparam int SEL_W = nr_sel_width(CHANNELS);

    nr_state_e           state_r;
    nr_state_e           state_next_s;
    logic                can_load_s;
    logic                en_s;
    logic [CHANNELS-1:0] grant_s;
    logic [SEL_W-1:0]    grant_idx_s;
    logic                xfer_s;
    logic [WIDTH-1:0]    sel_data_s;
    logic [WIDTH-1:0]    data_r;
    logic [SEL_W-1:0]    sel_r;

    // Reset forces the grant low so no handshake completes while rst is high.
    assign can_load_s = (state_r == NR_EMPTY) | bus.out_ready;
    assign en_s       = can_load_s & ~rst;

    nr_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .MODE     (MODE),
        .SEL_W    (SEL_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.in_valid),
        .en        (en_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (xfer_s)
    );

    // Output slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= NR_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: load on transfer, drain on out_ready without a replacement.
    always_comb begin
        case (state_r)
            NR_EMPTY: state_next_s = xfer_s ? NR_FULL : NR_EMPTY;
            NR_FULL: begin
                if (xfer_s) begin
                    state_next_s = NR_FULL;
                end else if (bus.out_ready) begin
                    state_next_s = NR_EMPTY;
                end else begin
                    state_next_s = NR_FULL;
                end
            end
            default: state_next_s = NR_EMPTY;
        endcase
    end

    // Handshake outputs derived from the state and the grant.
    always_comb begin
        bus.out_valid = (state_r == NR_FULL);
        bus.in_ready  = grant_s;
    end

    // Pick the granted channel's word; only the registered copy reaches out_data.
    always_comb begin
        sel_data_s = bus.in_data[int'(grant_idx_s)*WIDTH +: WIDTH];
    end

    // Output data and source-channel registers, loaded only on a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= '0;
            sel_r  <= '0;
        end else if (xfer_s) begin
            data_r <= sel_data_s;
            sel_r  <= grant_idx_s;
        end else begin
            data_r <= data_r;
            sel_r  <= sel_r;
        end
    end

    assign bus.out_data = data_r;
    assign bus.out_sel  = sel_r;

endmodule

// File: tb/tb_nr_arb_mux.sv
// Scoreboard bench for nr_arb_mux: fixed/4ch, round-robin/4ch and round-robin/3ch instances.
module tb_nr_arb_mux;
    import nr_pkg::*;

    logic       clk;
    logic       rst;
    int         act;
    logic [3:0] tb_valid;
    logic       tb_oready;
    logic [7:0] tb_d [4];

    logic [3:0] obs_rdy;
    logic       obs_ov;
    logic [7:0] obs_data;
    logic [1:0] obs_sel;

    int         n_chk;
    int         n_fail;
    int         mode_m;
    int         chans_m;
    int         m_ptr;
    logic       m_ov;
    logic [15:0] sb [$];

    nr_arb_mux_if #(.WIDTH(8), .CHANNELS(4)) bf ();
    nr_arb_mux_if #(.WIDTH(8), .CHANNELS(4)) br ();
    nr_arb_mux_if #(.WIDTH(8), .CHANNELS(3)) b3 ();

    nr_arb_mux #(.WIDTH(8), .CHANNELS(4), .MODE(NR_ARB_FIXED)) u_fix (.clk(clk), .rst(rst), .bus(bf));
    nr_arb_mux #(.WIDTH(8), .CHANNELS(4), .MODE(NR_ARB_RR))    u_rr4 (.clk(clk), .rst(rst), .bus(br));
    nr_arb_mux #(.WIDTH(8), .CHANNELS(3), .MODE(NR_ARB_RR))    u_rr3 (.clk(clk), .rst(rst), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bf.in_data   = {tb_d[3], tb_d[2], tb_d[1], tb_d[0]};
    assign br.in_data   = {tb_d[3], tb_d[2], tb_d[1], tb_d[0]};
    assign b3.in_data   = {tb_d[2], tb_d[1], tb_d[0]};
    assign bf.in_valid  = (act == 0) ? tb_valid : 4'b0000;
    assign br.in_valid  = (act == 1) ? tb_valid : 4'b0000;
    assign b3.in_valid  = (act == 2) ? tb_valid[2:0] : 3'b000;
    assign bf.out_ready = (act == 0) ? tb_oready : 1'b1;
    assign br.out_ready = (act == 1) ? tb_oready : 1'b1;
    assign b3.out_ready = (act == 2) ? tb_oready : 1'b1;

    always_comb begin
        obs_rdy  = 4'b0000;
        obs_ov   = 1'b0;
        obs_data = 8'h00;
        obs_sel  = 2'b00;
        case (act)
            0: begin obs_rdy = bf.in_ready; obs_ov = bf.out_valid; obs_data = bf.out_data; obs_sel = bf.out_sel; end
            1: begin obs_rdy = br.in_ready; obs_ov = br.out_valid; obs_data = br.out_data; obs_sel = br.out_sel; end
            2: begin obs_rdy = {1'b0, b3.in_ready}; obs_ov = b3.out_valid; obs_data = b3.out_data; obs_sel = b3.out_sel; end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference arbiter: first requester from the start point, -1 when none.
    function automatic int model_pick(input logic [3:0] v);
        int idx;
        for (int i = 0; i < chans_m; i++) begin
            idx = ((mode_m == NR_ARB_RR) ? m_ptr : 0) + i;
            if (idx >= chans_m) idx = idx - chans_m;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Drive one cycle, check handshakes against the model, then advance the model.
    task automatic cycle(input logic [3:0] v, input logic ordy);
        int g;
        logic [3:0] eg;
        logic [15:0] e;
        @(negedge clk);
        tb_valid  = v;
        tb_oready = ordy;
        #1;
        g  = model_pick(v);
        eg = ((g >= 0) && (!m_ov || ordy)) ? (4'b0001 << g) : 4'b0000;
        check_eq("in_ready", {28'd0, obs_rdy}, {28'd0, eg});
        check_eq("out_valid", {31'd0, obs_ov}, {31'd0, m_ov});
        if (m_ov && ordy) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("out_data", {24'd0, obs_data}, {24'd0, e[15:8]});
                check_eq("out_sel", {30'd0, obs_sel}, {30'd0, e[1:0]});
            end else begin
                check_eq("sb_underflow", sb.size(), 32'd1);
            end
        end
        if (eg != 4'b0000) begin
            sb.push_back({tb_d[g], 8'(g)});
            if (mode_m == NR_ARB_RR) m_ptr = (g == chans_m - 1) ? 0 : g + 1;
            m_ov = 1'b1;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
    endtask

    // Reset all instances, select the active one and check reset outputs.
    task automatic do_reset(input int which, input int mode, input int chans);
        @(negedge clk);
        rst       = 1'b1;
        act       = which;
        tb_valid  = 4'b1111;
        tb_oready = 1'b1;
        #1;
        check_eq("rst_in_ready", {28'd0, obs_rdy}, 32'd0);
        check_eq("rst_out_valid", {31'd0, obs_ov}, 32'd0);
        check_eq("rst_out_data", {24'd0, obs_data}, 32'd0);
        check_eq("rst_out_sel", {30'd0, obs_sel}, 32'd0);
        sb.delete();
        m_ov    = 1'b0;
        m_ptr   = 0;
        mode_m  = mode;
        chans_m = chans;
        @(posedge clk);
        #1;
        check_eq("rst_hold_valid", {31'd0, obs_ov}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        tb_valid = 4'b0000;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; act = 0; tb_valid = 4'b0000; tb_oready = 1'b1;
        m_ov = 1'b0; m_ptr = 0; mode_m = NR_ARB_FIXED; chans_m = 4;
        for (int c = 0; c < 4; c++) tb_d[c] = 8'h00;
        repeat (2) @(posedge clk);

        // Fixed priority
        do_reset(0, NR_ARB_FIXED, 4);
        tb_d[0] = 8'hA0; tb_d[1] = 8'h11; tb_d[2] = 8'h22; tb_d[3] = 8'h33;
        cycle(4'b1111, 1'b1);
        check_eq("first_grant_ch0", {28'd0, obs_rdy}, 32'h1);
        cycle(4'b1010, 1'b1);
        check_eq("fix_grant_ch1", {28'd0, obs_rdy}, 32'h2);
        cycle(4'b1010, 1'b1);
        check_eq("fix_data_11", {24'd0, obs_data}, 32'h11);
        check_eq("fix_sel_1", {30'd0, obs_sel}, 32'h1);
        repeat (3) cycle(4'b1010, 1'b1);

        // Backpressure and same-edge replacement
        cycle(4'b0000, 1'b1);
        cycle(4'b0100, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(4'b0100, 1'b0);
            check_eq("bp_hold_data", {24'd0, obs_data}, 32'h22);
            check_eq("bp_in_ready", {28'd0, obs_rdy}, 32'h0);
        end
        tb_d[2] = 8'h5A;
        cycle(4'b0100, 1'b1);
        cycle(4'b0000, 1'b0);
        check_eq("repl_valid", {31'd0, obs_ov}, 32'h1);
        check_eq("repl_data", {24'd0, obs_data}, 32'h5A);
        check_eq("repl_sel", {30'd0, obs_sel}, 32'h2);

        // Drain, then out_ready pulses while empty
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        check_eq("drained", {31'd0, obs_ov}, 32'h0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b1);
        check_eq("empty_data_kept", {24'd0, obs_data}, 32'h5A);

        // Round-robin, 4 channels
        do_reset(1, NR_ARB_RR, 4);
        for (int c = 0; c < 4; c++) tb_d[c] = 8'hC0 + 8'(c);
        for (int k = 0; k < 5; k++) begin
            cycle(4'b1111, 1'b1);
            check_eq("rr4_seq", {28'd0, obs_rdy}, 32'h1 << (k % 4));
        end
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // Mid-operation reset with ptr = 2 and the slot full
        do_reset(1, NR_ARB_RR, 4);
        cycle(4'b1111, 1'b1);
        cycle(4'b1111, 1'b1);
        cycle(4'b1111, 1'b0);
        check_eq("pre_rst_full", {31'd0, obs_ov}, 32'h1);
        do_reset(1, NR_ARB_RR, 4);
        cycle(4'b1110, 1'b1);
        check_eq("post_rst_grant", {28'd0, obs_rdy}, 32'h2);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // Round-robin, 3 channels
        do_reset(2, NR_ARB_RR, 3);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b1111, 1'b1);
            check_eq("rr3_seq", {28'd0, obs_rdy}, 32'h1 << (k % 3));
        end
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        check_eq("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nr_arb_mux.md
# nr_arb_mux

Parametrised, registered N-to-1 datapath multiplexer with built-in arbitration and valid/ready handshakes. It generalises the processor's fixed 2- and 4-input 8-bit selectors. Several producers (register-file read ports, ALU result, memory return) compete for one destination bus. The block selects a requester by fixed priority or round-robin, transfers one word per cycle into an output register, and reports which channel each word came from.

## Interface
- WIDTH, 8, data width of every channel and of the output
- CHANNELS, 4, number of input channels, 1..16
- MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  channel c presents a word
- in_ready  output  CHANNELS  one-hot-or-zero grant; channel c word accepted when in_valid[c] & in_ready[c]
- out_data  output  WIDTH  registered selected word
- out_valid  output  1  out_data holds an untaken word
- out_ready  input  1  consumer accepts out_data this cycle
- out_sel  output  SEL_W  index of the channel that produced out_data; SEL_W = max(1, clog2(CHANNELS))

## Operation
- The two-state FSM is encoded by out_valid: EMPTY (0) and FULL (1).
- can_load = ~out_valid | out_ready. This is the output slot free now or draining this cycle.
- Arbiter: when can_load, grant exactly one channel with in_valid set; in_ready is the grant vector. When ~can_load or no requests, in_ready = 0.
- in_ready is combinational from in_valid, out_valid, out_ready and the pointer. Producers must not make in_valid depend on in_ready.
- Fixed mode: grant the lowest-index requester. The pointer is unused and held at 0.
- Round-robin mode: search starts at ptr, wraps at CHANNELS-1 to 0, and grants the first requester. On a transfer from channel g, ptr <= (g == CHANNELS-1) ? 0 : g+1. With no transfer, ptr holds. This applies to any CHANNELS value, including non-powers of two.
- On a transfer from channel g: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- EMPTY -> FULL on a transfer.
- FULL -> EMPTY on out_ready with no new transfer.
- FULL -> FULL on a simultaneous drain and transfer. The new word replaces the old with no bubble.
- FULL with out_ready = 0: out_data, out_sel and out_valid are held stable, and in_ready = 0.
- out_ready while EMPTY is ignored.
- CHANNELS = 1: the block degenerates to a one-entry pipeline register, and out_sel is constantly 0.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
  - in_ready = 0 while rst is high, forced combinationally.
- Asserting rst mid-transfer discards the output word immediately. No handshake completes in a cycle where rst is high.
- Latency: a word accepted at edge N appears with out_valid = 1 after edge N.
- Throughput: one word per cycle while out_ready stays high.
- No combinational path from in_data to out_data. The combinational paths are in_valid -> in_ready and out_ready -> in_ready.

## Structure
- Shared package nr_pkg holds:
  - NR_ARB_FIXED = 0 and NR_ARB_RR = 1
  - function nr_sel_width(n), returning max(1, clog2(n))
- Sub-module nr_rr_arbiter contains:
  - the request vector, enable (can_load) and MODE
  - the grant vector and grant index
  - the ptr register and its update on accept
- The top level holds the output register, the FSM and the data selection from the grant index.

## Test plan
- Reset: assert rst with in_valid = 4'b1111 -> in_ready = 0, out_valid = 0, out_data = 0x00, out_sel = 0. Release rst -> the next cycle grants channel 0.
- Fixed priority (MODE = 0, out_ready = 1): in_valid = 4'b1010 with data ch1 = 0x11, ch3 = 0x33 -> in_ready = 4'b0010, then out_data = 0x11, out_sel = 1. Keep ch1 valid -> ch3 is never granted.
- Round-robin (MODE = 1): all four channels valid every cycle, data ch c = 0xC0+c -> out_sel sequence 0,1,2,3,0 with one word per cycle. Repeat with CHANNELS = 3 -> sequence 0,1,2,0.
- Backpressure: FULL with 0x22, out_ready = 0 for 3 cycles -> out_data stays 0x22 and in_ready = 0. Raise out_ready with ch2 valid (0x5A) -> same-edge replacement, out_valid stays 1, out_data = 0x5A.
- Drain: FULL, out_ready = 1, no requests -> out_valid = 0 next cycle. out_ready pulses while EMPTY -> no change.
- Mid-operation reset: round-robin ptr = 2, FULL -> rst pulse -> out_valid = 0 and ptr = 0. The first grant after release goes to the lowest valid index.
